// File: rtl/past_window_sum_decoder.sv
// rtl/past_window_sum_decoder.sv - inverse of the sliding-window adder: rebuilds x[n] from window sums y[n]
// Optional synchronous history clear via input flush when PAST_WINDOW_FLUSH_EN is defined.
module past_window_sum_decoder #(
  parameter int W  = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef PAST_WINDOW_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          primed
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(W);

  logic [DW-1:0] prev_y_q, prev_y_d;
  logic [DW-1:0] hist_q [W];
  logic [DW-1:0] hist_d [W];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          primed_q, primed_d;
  logic          flush_w;
  logic          accept;
  logic [DW-1:0] x_new;

`ifdef PAST_WINDOW_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_ready = !flush_w && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  // x[n] = y[n] - y[n-1] + x[n-W]; history starts at zero, so early samples are exact too
  assign x_new    = in_data - prev_y_q + hist_q[W-1];

  always_comb begin
    prev_y_d    = prev_y_q;
    hist_d      = hist_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (flush_w) begin
      prev_y_d    = '0;
      for (int i = 0; i < W; i++) hist_d[i] = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      prev_y_d    = in_data;
      hist_d[0]   = x_new;
      for (int i = 1; i < W; i++) hist_d[i] = hist_q[i-1];
      cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      out_valid_d = 1'b1;
      out_data_d  = x_new;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    primed_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_y_q    <= '0;
      for (int i = 0; i < W; i++) hist_q[i] <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      primed_q    <= 1'b0;
    end else begin
      prev_y_q    <= prev_y_d;
      for (int i = 0; i < W; i++) hist_q[i] <= hist_d[i];
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      primed_q    <= primed_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign primed    = primed_q;

endmodule
